// File: rtl/math_pkg.sv
// ============================================================================
//  Module      : math_pkg
//  Description : Shared types and helpers for the math library. Holds the
//                iterative divider FSM state type and its latency helper.
//  Revision    : 1.0 - initial release with div_iter support
// ============================================================================
`default_nettype none

package math_pkg;

  // Iterative divider control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // Cycles from the accepting edge until out_valid_o is observed high:
  // A_DW restoring steps plus one sign-fixup cycle.
  function automatic int unsigned div_latency(input int unsigned a_dw);
    return a_dw + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
//  Module      : div_step
//  Description : One combinational radix-2 restoring division step.
//  Ports       : rem      - current partial remainder (B_DW+1 bits)
//                quo_msb  - bit shifted in from the quotient register
//                dvs      - divisor magnitude
//                rem_next - partial remainder after this step
//                q_bit    - quotient bit produced by this step
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_step #(
  parameter int B_DW = 8
) (
  input  logic [B_DW:0]   rem,
  input  logic            quo_msb,
  input  logic [B_DW-1:0] dvs,
  output logic [B_DW:0]   rem_next,
  output logic            q_bit
);

  // One extra bit above the shifted remainder so the trial subtraction
  // exposes its sign in the MSB.
  logic [B_DW+1:0] shifted;
  logic [B_DW+1:0] trial;

  assign shifted  = {rem, quo_msb};
  assign trial    = shifted - {2'b00, dvs};
  assign q_bit    = ~trial[B_DW+1];
  assign rem_next = q_bit ? trial[B_DW:0] : shifted[B_DW:0];

endmodule

`default_nettype wire

// File: rtl/div_iter.sv
// ============================================================================
//  Module      : div_iter
//  Description : Iterative radix-2 restoring divider, signed or unsigned,
//                one operand pair per valid/ready handshake.
//  Ports       : clk, rst_n          - clock, async active-low reset
//                tc_mode_i           - 1 = two's complement, 0 = unsigned
//                in_valid_i/in_ready_o   - operand handshake
//                a_i, b_i            - dividend, divisor
//                out_valid_o/out_ready_i - result handshake
//                q_o, r_o, dz_o      - quotient, remainder, divide-by-zero
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_iter
  import math_pkg::*;
#(
  parameter int A_DW = 8,
  parameter int B_DW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tc_mode_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [A_DW-1:0] a_i,
  input  logic [B_DW-1:0] b_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [A_DW-1:0] q_o,
  output logic [B_DW-1:0] r_o,
  output logic            dz_o
);

  localparam int              CNT_W = $clog2(A_DW);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(A_DW - 1);

  div_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic [B_DW:0]   rem;
  logic [A_DW-1:0] quo;
  logic [B_DW-1:0] b_mag;
  logic [B_DW-1:0] a_lo;     // low dividend bits, the remainder on divide-by-zero
  logic            sq;       // quotient negative
  logic            sr;       // remainder negative (follows dividend)
  logic            dz;

  logic            a_neg;
  logic            b_neg;
  logic [A_DW-1:0] a_mag;
  logic [B_DW:0]   step_rem;
  logic            step_q;

  // The most negative dividend negates onto itself, which reads correctly
  // as its unsigned magnitude.
  assign a_neg = tc_mode_i & a_i[A_DW-1];
  assign b_neg = tc_mode_i & b_i[B_DW-1];
  assign a_mag = a_neg ? (~a_i + A_DW'(1)) : a_i;

  assign in_ready_o  = (state == IDLE);
  assign out_valid_o = (state == DONE);

  div_step #(.B_DW(B_DW)) u_step (
    .rem      (rem),
    .quo_msb  (quo[A_DW-1]),
    .dvs      (b_mag),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      b_mag <= '0;
      a_lo  <= '0;
      sq    <= 1'b0;
      sr    <= 1'b0;
      dz    <= 1'b0;
      q_o   <= '0;
      r_o   <= '0;
      dz_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid_i) begin
            b_mag <= b_neg ? (~b_i + B_DW'(1)) : b_i;
            quo   <= a_mag;
            rem   <= '0;
            a_lo  <= a_i[B_DW-1:0];
            sq    <= a_neg ^ b_neg;
            sr    <= a_neg;
            dz    <= (b_i == '0);
            cnt   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          rem <= step_rem;
          quo <= {quo[A_DW-2:0], step_q};
          if (cnt == LAST) begin
            state <= FIX;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        FIX: begin
          // Signed overflow (-2^(A_DW-1) / -1) wraps naturally here.
          if (dz) begin
            q_o  <= '1;
            r_o  <= a_lo;
            dz_o <= 1'b1;
          end else begin
            q_o  <= sq ? (~quo + A_DW'(1)) : quo;
            r_o  <= sr ? (~rem[B_DW-1:0] + B_DW'(1)) : rem[B_DW-1:0];
            dz_o <= 1'b0;
          end
          state <= DONE;
        end
        DONE: begin
          if (out_ready_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
